// File: rtl/nn_pixel_feeder.sv
// nn_pixel_feeder
//   Front end for NN_Controler. Accepts grayscale pixels from the host over
//   valid/ready and binarizes each one against THRESHOLD (pixel >= THRESHOLD
//   gives 1). It buffers one frame, streams it as a 1-bit burst to the
//   controller, completes the prediction handshake, and holds the digit for
//   the host until the host acknowledges it.
//
// Ports
//   masterClk, reset       : clock and synchronous active-high reset
//   pixelIn/Valid/Ready    : host pixel stream, raster order, index 0 first
//   readyForInputs         : controller can take a burst
//   inputsInbound          : high for exactly NUM_PIXELS cycles per burst
//   inputPixel             : binarized pixel i during burst cycle i
//   predictionReady/Out    : controller result and its strobe
//   predictionRecieved     : handshake acknowledge to the controller
//   resultValid/Digit      : latched digit offered to the host
//   resultAck              : host consumed the result
//   frameCount             : completed frames, wraps modulo 2^16
module nn_pixel_feeder #(
  parameter int NUM_PIXELS  = 784,
  parameter int PIXEL_WIDTH = 8,
  parameter int THRESHOLD   = 128,
  parameter int INDEX_WIDTH = 10
) (
  input  logic                   masterClk,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] pixelIn,
  input  logic                   pixelValid,
  output logic                   pixelReady,
  input  logic                   readyForInputs,
  output logic                   inputsInbound,
  output logic                   inputPixel,
  input  logic                   predictionReady,
  input  logic [3:0]             predictionOut,
  output logic                   predictionRecieved,
  output logic                   resultValid,
  output logic [3:0]             resultDigit,
  input  logic                   resultAck,
  output logic [15:0]            frameCount
);

  // Buffer address width; the low bits of the pixel counter address the buffer.
  localparam int BUF_IW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_PIXELS - 1);
  localparam logic [PIXEL_WIDTH-1:0] THRESH   = PIXEL_WIDTH'(THRESHOLD);

  typedef enum logic [2:0] {
    LOAD, WAIT_NN, STREAM, WAIT_PRED, ACK, RESULT
  } state_t;

  state_t                 state;
  logic [NUM_PIXELS-1:0]  frameBuf;
  logic [INDEX_WIDTH-1:0] idx;
  logic [INDEX_WIDTH-1:0] nextIdx;

  assign nextIdx = idx + 1'b1;

  always_ff @(posedge masterClk) begin
    if (reset) begin
      state              <= LOAD;
      idx                <= '0;
      pixelReady         <= 1'b1;
      inputsInbound      <= 1'b0;
      inputPixel         <= 1'b0;
      predictionRecieved <= 1'b0;
      resultValid        <= 1'b0;
      resultDigit        <= 4'd0;
      frameCount         <= 16'd0;
    end else begin
      case (state)
        LOAD: begin
          // pixelReady is 1 throughout LOAD, so pixelValid alone is a transfer.
          if (pixelValid) begin
            frameBuf[idx[BUF_IW-1:0]] <= (pixelIn >= THRESH);
            if (idx == LAST_IDX) begin
              idx        <= '0;
              pixelReady <= 1'b0;
              state      <= WAIT_NN;
            end else begin
              idx <= nextIdx;
            end
          end
        end
        WAIT_NN: begin
          if (readyForInputs) begin
            inputsInbound <= 1'b1;
            inputPixel    <= frameBuf[0];
            idx           <= '0;
            state         <= STREAM;
          end
        end
        STREAM: begin
          // idx is the pixel currently on inputPixel; readyForInputs is not
          // consulted so the burst always runs to completion.
          if (idx == LAST_IDX) begin
            inputsInbound <= 1'b0;
            inputPixel    <= 1'b0;
            idx           <= '0;
            state         <= WAIT_PRED;
          end else begin
            inputPixel <= frameBuf[nextIdx[BUF_IW-1:0]];
            idx        <= nextIdx;
          end
        end
        WAIT_PRED: begin
          if (predictionReady) begin
            resultDigit        <= predictionOut;
            predictionRecieved <= 1'b1;
            state              <= ACK;
          end
        end
        ACK: begin
          if (!predictionReady) begin
            predictionRecieved <= 1'b0;
            resultValid        <= 1'b1;
            state              <= RESULT;
          end
        end
        RESULT: begin
          if (resultAck && resultValid) begin
            resultValid <= 1'b0;
            frameCount  <= frameCount + 16'd1;
            pixelReady  <= 1'b1;
            state       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_pixel_feeder.sv
// Bench for nn_pixel_feeder with a 6-pixel frame. A frame-level model keeps
// the expected binarized bits (queued as pixels are handed over), the
// expected digit and the expected frame count; a per-cycle compare checks the
// burst contents and length plus the result outputs against it. Directed
// literal checks cover reset values, latencies and the handshake timing.
module tb_nn_pixel_feeder;
  localparam int NUM = 6;

  logic       masterClk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pixelIn = 8'd0;
  logic       pixelValid = 1'b0;
  logic       pixelReady;
  logic       readyForInputs = 1'b0;
  logic       inputsInbound;
  logic       inputPixel;
  logic       predictionReady = 1'b0;
  logic [3:0] predictionOut = 4'd0;
  logic       predictionRecieved;
  logic       resultValid;
  logic [3:0] resultDigit;
  logic       resultAck = 1'b0;
  logic [15:0] frameCount;

  nn_pixel_feeder #(.NUM_PIXELS(NUM), .PIXEL_WIDTH(8), .THRESHOLD(128), .INDEX_WIDTH(10)) dut (
    .masterClk(masterClk), .reset(reset),
    .pixelIn(pixelIn), .pixelValid(pixelValid), .pixelReady(pixelReady),
    .readyForInputs(readyForInputs), .inputsInbound(inputsInbound), .inputPixel(inputPixel),
    .predictionReady(predictionReady), .predictionOut(predictionOut),
    .predictionRecieved(predictionRecieved),
    .resultValid(resultValid), .resultDigit(resultDigit), .resultAck(resultAck),
    .frameCount(frameCount)
  );

  always #5 masterClk = ~masterClk;

  int nChecks = 0;
  int nFails  = 0;

  // Model state
  bit         expBits[$];
  logic [3:0] expDigit = 4'd0;
  int         expFrames = 0;
  logic [7:0] framePix [NUM];

  // Observation of the most recent burst
  logic [NUM-1:0] obsBits;
  int  burstLen = 0;
  int  lastLen = 0;
  int  burstsDone = 0;
  bit  cmpEn = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    nChecks++;
    if (!ok) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model; runs at the falling edge before
  // the bench changes any input for the next rising edge.
  task automatic cycleCompare();
    bit b;
    if (!cmpEn) return;
    if (inputsInbound) begin
      if (burstLen == 0) obsBits = '0;
      if (expBits.size() == 0) begin
        check(1'b0, "stream_extra_pixel", burstLen, NUM);
      end else begin
        b = expBits.pop_front();
        check(inputPixel == b, "stream_pixel", int'(inputPixel), int'(b));
      end
      if (burstLen < NUM) obsBits[burstLen] = inputPixel;
      burstLen++;
    end else begin
      check(inputPixel == 1'b0, "idle_inputPixel", int'(inputPixel), 0);
      if (burstLen != 0) begin
        // A reset sampled at the edge that ended the burst aborts it.
        if (reset) expBits.delete();
        else check(burstLen == NUM, "burst_length", burstLen, NUM);
        lastLen = burstLen;
        burstLen = 0;
        burstsDone++;
      end
    end
    if (resultValid)
      check(resultDigit == expDigit, "result_digit", int'(resultDigit), int'(expDigit));
    check(int'(frameCount) == expFrames, "frame_count", int'(frameCount), expFrames);
    check(!(resultValid && predictionRecieved), "valid_and_recieved", int'(resultValid), 0);
  endtask

  task automatic tick();
    @(negedge masterClk);
    cycleCompare();
  endtask

  // Hand the frame in framePix to the DUT; gapped inserts an idle cycle
  // (with decoy data) before every transfer.
  task automatic loadFrame(input bit gapped);
    for (int i = 0; i < NUM; i++) begin
      if (gapped) begin
        pixelValid = 1'b0;
        pixelIn = ~framePix[i];
        tick();
      end
      check(pixelReady == 1'b1, "load_pixelReady", int'(pixelReady), 1);
      pixelIn = framePix[i];
      pixelValid = 1'b1;
      expBits.push_back(framePix[i] >= 8'd128);
      tick();
    end
    pixelValid = 1'b0;
    check(pixelReady == 1'b0, "loaded_pixelReady", int'(pixelReady), 0);
  endtask

  task automatic waitBurstEnd();
    int start = burstsDone;
    int n = 0;
    while (burstsDone == start && n < 60) begin
      tick();
      n++;
    end
    if (burstsDone == start) check(1'b0, "burst_timeout", n, 60);
  endtask

  task automatic ackResult();
    resultAck = 1'b1;
    expFrames++;
    tick();
    resultAck = 1'b0;
    check(resultValid == 1'b0, "ack_resultValid", int'(resultValid), 0);
    check(pixelReady == 1'b1, "ack_pixelReady", int'(pixelReady), 1);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    cmpEn = 1'b1;
    check(pixelReady == 1'b1, "rst_pixelReady", int'(pixelReady), 1);
    check(inputsInbound == 1'b0, "rst_inputsInbound", int'(inputsInbound), 0);
    check(inputPixel == 1'b0, "rst_inputPixel", int'(inputPixel), 0);
    check(predictionRecieved == 1'b0, "rst_predictionRecieved", int'(predictionRecieved), 0);
    check(resultValid == 1'b0, "rst_resultValid", int'(resultValid), 0);
    check(resultDigit == 4'd0, "rst_resultDigit", int'(resultDigit), 0);
    check(frameCount == 16'd0, "rst_frameCount", int'(frameCount), 0);
    reset = 1'b0;
    tick();

    // Frame 1: basic frame with the controller ready throughout
    readyForInputs = 1'b1;
    framePix = '{8'd10, 8'd200, 8'd128, 8'd127, 8'd255, 8'd0};
    loadFrame(1'b0);
    tick();
    check(inputsInbound == 1'b1, "burst_start_latency", int'(inputsInbound), 1);
    pixelValid = 1'b1;  // ignored during STREAM / WAIT_PRED
    pixelIn = 8'd255;
    waitBurstEnd();
    check(obsBits == 6'b010110, "frame1_bits", int'(obsBits), 'b010110);
    check(lastLen == 6, "frame1_len", lastLen, 6);
    check(pixelReady == 1'b0, "wait_pred_pixelReady", int'(pixelReady), 0);

    // Prediction handshake; predictionOut changes after the latch
    predictionReady = 1'b1;
    predictionOut = 4'd7;
    expDigit = 4'd7;
    tick();
    check(predictionRecieved == 1'b1, "pred_recieved_rise", int'(predictionRecieved), 1);
    predictionOut = 4'd3;
    resultAck = 1'b1;  // ignored outside RESULT
    tick();
    resultAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check(predictionRecieved == 1'b1, "pred_recieved_hold", int'(predictionRecieved), 1);
      check(resultValid == 1'b0, "pred_resultValid_low", int'(resultValid), 0);
    end
    predictionReady = 1'b0;
    tick();
    check(predictionRecieved == 1'b0, "pred_recieved_fall", int'(predictionRecieved), 0);
    check(resultValid == 1'b1, "resultValid_rise", int'(resultValid), 1);
    check(resultDigit == 4'd7, "resultDigit_latched", int'(resultDigit), 7);
    for (int i = 0; i < 10; i++) begin
      tick();
      check(resultValid == 1'b1, "result_hold_valid", int'(resultValid), 1);
      check(resultDigit == 4'd7, "result_hold_digit", int'(resultDigit), 7);
      check(pixelReady == 1'b0, "result_pixelReady", int'(pixelReady), 0);
    end
    pixelValid = 1'b0;
    ackResult();
    check(frameCount == 16'd1, "frameCount_1", int'(frameCount), 1);

    // Frame 2: all 255, controller backpressure, prediction high on entry
    readyForInputs = 1'b0;
    for (int i = 0; i < NUM; i++) framePix[i] = 8'd255;
    loadFrame(1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check(inputsInbound == 1'b0, "bp_inputsInbound", int'(inputsInbound), 0);
      check(pixelReady == 1'b0, "bp_pixelReady", int'(pixelReady), 0);
    end
    readyForInputs = 1'b1;
    tick();
    check(inputsInbound == 1'b1, "bp_release_start", int'(inputsInbound), 1);
    tick();
    readyForInputs = 1'b0;  // drop mid-burst: burst must still be full length
    predictionReady = 1'b1;
    predictionOut = 4'd5;
    expDigit = 4'd5;
    waitBurstEnd();
    check(obsBits == 6'b111111, "frame2_bits", int'(obsBits), 'b111111);
    check(lastLen == 6, "frame2_len", lastLen, 6);
    tick();
    check(predictionRecieved == 1'b1, "pred_on_entry", int'(predictionRecieved), 1);
    predictionReady = 1'b0;
    tick();
    check(resultDigit == 4'd5, "frame2_digit", int'(resultDigit), 5);
    ackResult();
    check(frameCount == 16'd2, "frameCount_2", int'(frameCount), 2);

    // Reset during burst cycle 3
    readyForInputs = 1'b1;
    framePix = '{8'd200, 8'd0, 8'd200, 8'd0, 8'd200, 8'd0};
    loadFrame(1'b0);
    tick();
    tick();
    tick();
    check(inputsInbound == 1'b1, "pre_reset_inbound", int'(inputsInbound), 1);
    reset = 1'b1;
    expFrames = 0;
    tick();
    check(inputsInbound == 1'b0, "mid_reset_inbound", int'(inputsInbound), 0);
    check(pixelReady == 1'b1, "mid_reset_pixelReady", int'(pixelReady), 1);
    check(lastLen == 3, "aborted_len", lastLen, 3);
    reset = 1'b0;
    tick();

    // Recovery frame loaded with gaps between transfers
    framePix = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd129, 8'd127};
    loadFrame(1'b1);
    waitBurstEnd();
    check(obsBits == 6'b011010, "frame3_bits", int'(obsBits), 'b011010);
    check(lastLen == 6, "frame3_len", lastLen, 6);
    predictionReady = 1'b1;
    predictionOut = 4'd9;
    expDigit = 4'd9;
    tick();
    predictionReady = 1'b0;
    tick();
    tick();
    check(resultDigit == 4'd9, "frame3_digit", int'(resultDigit), 9);
    ackResult();
    check(frameCount == 16'd1, "frameCount_after_reset", int'(frameCount), 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end
endmodule
